// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers, with a bounded burst lock of up to BURST_MAX words.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   req          per-producer write request (level)
//   req_data     producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full    FIFO full flag; no grant while high
//   gnt          one-hot grant, combinational (word accepted at the edge)
//   fifo_w_en    FIFO write enable (= |gnt)
//   fifo_data_in word of the granted producer, 0 when no grant
//   busy         registered, high while a burst lock is held
//   stall_cnt    (ARB_STATS_EN) saturating count of cycles with |req && fifo_full
//   gnt_total    (ARB_STATS_EN) wrapping count of accepted words
//
// Optional feature macro: ARB_STATS_EN
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
`ifdef ARB_STATS_EN
  output logic [15:0]                   stall_cnt,
  output logic [15:0]                   gnt_total,
`endif
  output logic                          busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);
  localparam bit          MULTI = (BURST_MAX > 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] last_q;
  logic [CNT_W-1:0] burst_cnt_q;
  logic             busy_q;

  logic             hold_c;
  logic             pick_vld_c;
  logic [IDX_W-1:0] pick_idx_c;
  logic             win_vld_c;
  logic [IDX_W-1:0] win_idx_c;

  // Round-robin pick starting after last, plus grant and data steering.
  // Grant is gated by rst so outputs drop immediately on an async reset.
  always_comb begin
    pick_vld_c   = 1'b0;
    pick_idx_c   = '0;
    gnt          = '0;
    fifo_data_in = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((32'(last_q) + k) % NUM_REQ);
      if (!pick_vld_c && req[cand]) begin
        pick_vld_c = 1'b1;
        pick_idx_c = cand;
      end
    end
    hold_c    = (state_q == BURST) && req[owner_q] && (burst_cnt_q < CNT_W'(BURST_MAX));
    win_vld_c = !rst && !fifo_full && (hold_c || pick_vld_c);
    win_idx_c = hold_c ? owner_q : pick_idx_c;
    if (win_vld_c) begin
      gnt[win_idx_c] = 1'b1;
      fifo_data_in   = req_data[32'(win_idx_c)*DATA_WIDTH +: DATA_WIDTH];
    end
    fifo_w_en = win_vld_c;
  end

  // Arbitration state; everything holds while the FIFO is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else if (!fifo_full) begin
      if (hold_c) begin
        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
        if (burst_cnt_q + CNT_W'(1) == CNT_W'(BURST_MAX)) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end else if (pick_vld_c) begin
        owner_q     <= pick_idx_c;
        last_q      <= pick_idx_c;
        burst_cnt_q <= CNT_W'(1);
        state_q     <= MULTI ? BURST : IDLE;
        busy_q      <= MULTI;
      end else begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        burst_cnt_q <= '0;
      end
    end
  end

  assign busy = busy_q;

`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] gnt_total_q;

  // Stall counter saturates; accepted-word counter wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      gnt_total_q <= '0;
    end else begin
      if (|req && fifo_full && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (fifo_w_en) gnt_total_q <= gnt_total_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign gnt_total = gnt_total_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus random traffic,
// checked against a quota-based reference model for BURST_MAX=4 and 1.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic              fifo_full;

  logic [NR-1:0] gnt0, gnt1;
  logic          wen0, wen1;
  logic [DW-1:0] d0, d1;
  logic          busy0, busy1;
`ifdef ARB_STATS_EN
  logic [15:0]   stall0, tot0, stall1, tot1;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(4)) dut0 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .fifo_full(fifo_full),
    .gnt(gnt0), .fifo_w_en(wen0), .fifo_data_in(d0),
`ifdef ARB_STATS_EN
    .stall_cnt(stall0), .gnt_total(tot0),
`endif
    .busy(busy0));

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .fifo_full(fifo_full),
    .gnt(gnt1), .fifo_w_en(wen1), .fifo_data_in(d1),
`ifdef ARB_STATS_EN
    .stall_cnt(stall1), .gnt_total(tot1),
`endif
    .busy(busy1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a lock owner with a remaining word quota, and the
  // position of the last round-robin winner.
  int bmax   [2];
  int m_lock [2];
  int m_left [2];
  int m_last [2];
  int m_stall, m_tot;

  logic [NR-1:0] obs_gnt0, obs_gnt1;
  logic          obs_wen0, obs_busy1;

  function automatic int exp_win(input int k);
    if (rst || fifo_full) return -1;
    if (m_lock[k] >= 0 && m_left[k] > 0 && req[m_lock[k]]) return m_lock[k];
    for (int j = 1; j <= NR; j++) begin
      int c;
      c = (m_last[k] + j) % NR;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_lock[k] = -1;
      m_left[k] = 0;
      m_last[k] = NR - 1;
    end
    m_stall = 0;
    m_tot   = 0;
  endtask

  // One clock: randomize data, check outputs at negedge, advance the model.
  task automatic cycle();
    int            w [2];
    logic [NR-1:0] eg;
    logic [DW-1:0] ed;
    logic [NR-1:0] ag [2];
    logic          aw [2];
    logic [DW-1:0] ad [2];
    logic          ab [2];
    req_data = $urandom;
    @(negedge clk);
    ag[0] = gnt0; aw[0] = wen0; ad[0] = d0; ab[0] = busy0;
    ag[1] = gnt1; aw[1] = wen1; ad[1] = d1; ab[1] = busy1;
    for (int k = 0; k < 2; k++) begin
      w[k] = exp_win(k);
      eg = '0;
      ed = '0;
      if (w[k] >= 0) begin
        eg[w[k]] = 1'b1;
        ed = req_data[w[k]*DW +: DW];
      end
      check(k == 0 ? "gnt_b4" : "gnt_b1", ag[k], eg);
      check(k == 0 ? "wen_b4" : "wen_b1", aw[k], w[k] >= 0);
      check(k == 0 ? "data_b4" : "data_b1", ad[k], ed);
      check(k == 0 ? "busy_b4" : "busy_b1", ab[k], (m_lock[k] >= 0 && m_left[k] > 0));
    end
`ifdef ARB_STATS_EN
    check("stall_cnt", stall0, m_stall);
    check("gnt_total", tot0, m_tot);
`endif
    obs_gnt0 = gnt0; obs_gnt1 = gnt1; obs_wen0 = wen0; obs_busy1 = busy1;
    @(posedge clk);
    if (!rst) begin
      if (|req && fifo_full && m_stall < 65535) m_stall++;
      if (w[0] >= 0) m_tot = (m_tot + 1) % 65536;
    end
    for (int k = 0; k < 2; k++) begin
      if (!rst && !fifo_full) begin
        if (w[k] < 0) begin
          m_lock[k] = -1;
          m_left[k] = 0;
        end else if (w[k] == m_lock[k] && m_left[k] > 0) begin
          m_left[k]--;
        end else begin
          m_lock[k] = w[k];
          m_last[k] = w[k];
          m_left[k] = bmax[k] - 1;
        end
      end
    end
    #1;
  endtask

  // Assert reset between edges, check outputs drop at once, then release.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_gnt", {gnt1, gnt0}, 0);
    check("rst_wen", {wen1, wen0}, 0);
    check("rst_busy", {busy1, busy0}, 0);
    check("rst_data", {d1, d0}, 0);
    @(negedge clk);
    rst       = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    m_reset();
`ifdef ARB_STATS_EN
    #1;
    check("rst_stall", stall0, 0);
    check("rst_total", tot0, 0);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    bmax[0]   = 4;
    bmax[1]   = 1;
    rst       = 1'b1;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    m_reset();
    #12;
    do_reset();

    // All requesting: bursts of 4 in order 0..3; BURST_MAX=1 rotates every word.
    req = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      cycle();
      check("rr_order_b4", obs_gnt0, 32'(1) << (i / 4));
      check("rr_order_b1", obs_gnt1, 32'(1) << (i % 4));
    end

    // Owner drops early; next pick starts after it and the quota restarts.
    do_reset();
    req = 4'b0100;
    cycle(); check("drop_c1", obs_gnt0, 4'b0100);
    cycle(); check("drop_c2", obs_gnt0, 4'b0100);
    req = 4'b1001;
    cycle(); check("drop_c3", obs_gnt0, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      cycle(); check("drop_burst", obs_gnt0, 4'b1000);
    end
    cycle(); check("drop_rotate", obs_gnt0, 4'b0001);

    // Full stall mid-burst keeps the lock; owner 1 then gets exactly 2 words.
    do_reset();
    req = 4'b0010;
    cycle(); cycle();
    req = 4'b0011;
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_gnt", obs_gnt0, 0);
      check("stall_wen", obs_wen0, 0);
    end
    fifo_full = 1'b0;
    cycle(); check("resume_1", obs_gnt0, 4'b0010);
    cycle(); check("resume_2", obs_gnt0, 4'b0010);
    cycle(); check("resume_next", obs_gnt0, 4'b0001);

    // BURST_MAX=1 alternates between two requesters and never goes busy.
    do_reset();
    req = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("alt_b1", obs_gnt1, (i % 2 == 0) ? 4'b0001 : 4'b0100);
      check("alt_busy_b1", obs_busy1, 0);
    end

    // Async reset mid-burst with owner 1, then the next grant goes to 0.
    do_reset();
    req = 4'b0010;
    cycle(); cycle();
    #2;
    check("pre_rst_gnt", gnt0, 4'b0010);
    do_reset();
    req = 4'b1111;
    cycle(); check("post_rst_gnt", obs_gnt0, 4'b0001);

`ifdef ARB_STATS_EN
    do_reset();
    req = 4'b0001;
    fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    fifo_full = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    req = '0;
    cycle();
    check("stats_stall10", stall0, 10);
    check("stats_total3", tot0, 3);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      req       = NR'($urandom);
      fifo_full = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
